mips_multicycle_ctrl: RTL and testbench

//  Moore FSM control unit for the multicycle MIPS datapath; successor of the 4-state R-type-only controller.

---
 rtl/mips_multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Moore control unit for the multicycle MIPS datapath. Decodes R-type, LW,
//   SW, BEQ, BNE, ADDI and J, and drives every datapath enable and mux select.
//   Memory accesses (FETCH, MEM_READ, MEM_WRITE) can be stretched by MEM_WAIT
//   extra cycles. Undefined opcodes either trap (sticky until reset) or are
//   treated as a NOP, depending on TRAP_ON_ILLEGAL.
//
// Parameters
//   MEM_WAIT        extra cycles each memory access is held (0 = single cycle)
//   ALUOP_W         width of ALUOp (>=2); ADD=0, SUB=1, FUNCT=2
//   TRAP_ON_ILLEGAL 1: undefined Op -> TRAP; 0: undefined Op -> FETCH
//
// Ports
//   Clk, Reset      clock (rising edge), asynchronous active-low reset
//   Op              opcode field of IR, used in DECODE and BRANCH only
//   PCWriteCond     conditional PC write (datapath gates with Zero ^ BranchNe)
//   PCWrite         unconditional PC write
//   BranchNe        invert Zero for BNE
//   IorD            memory address select: 0 = PC, 1 = ALUOut
//   MemWrite        memory write strobe
//   MemtoReg        register write data: 0 = ALUOut, 1 = MDR
//   IRWrite         load IR
//   MDRWrite        load MDR
//   PCSource        00 = ALU result, 01 = ALUOut, 10 = jump target
//   ALUOp           ALU operation class
//   ALUSrcA         0 = PC, 1 = A
//   ALUSrcB         00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
//   RegWrite        register-file write
//   RegDst          0 = rt, 1 = rd
//   AWrite, BWrite  load A / B
//   ALUOutWrite     load ALUOut
//   Illegal         high while in TRAP
//   State           current state encoding (debug)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT        = 0,
  parameter int ALUOP_W         = 3,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [5:0]         Op,
  output logic               PCWriteCond,
  output logic               PCWrite,
  output logic               BranchNe,
  output logic               IorD,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               MDRWrite,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               AWrite,
  output logic               BWrite,
  output logic               ALUOutWrite,
  output logic               Illegal,
  output logic [3:0]         State
);

  typedef enum logic [3:0] {
    RST_ST    = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    RTYPE     = 4'd7,
    RTYPE_WB  = 4'd8,
    ADDI_EX   = 4'd9,
    ADDI_WB   = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12,
    TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  // Wait counter is at least one bit wide so MEM_WAIT=0 still builds.
  localparam int               WC_W    = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(MEM_WAIT);

  state_t          state, state_next;
  logic [WC_W-1:0] wc, wc_next;
  logic            is_store, is_store_next;
  logic            last;
  logic            mem_state;

  assign last      = (wc == WC_LAST);
  assign mem_state = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= RST_ST;
      wc       <= '0;
      is_store <= 1'b0;
    end else begin
      state    <= state_next;
      wc       <= wc_next;
      is_store <= is_store_next;
    end
  end

  // Next-state logic. LW/SW direction is latched at DECODE so an Op change
  // after DECODE cannot redirect MEM_ADDR.
  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    is_store_next = is_store;
    unique case (state)
      RST_ST: state_next = FETCH;
      FETCH:  if (last) state_next = DECODE;
      DECODE: begin
        is_store_next = (Op == OP_SW);
        case (Op)
          OP_RTYPE:     state_next = RTYPE;
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_BEQ,
          OP_BNE:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDI_EX;
          OP_J:         state_next = JUMP;
          default:      state_next = TRAP_ON_ILLEGAL ? TRAP : FETCH;
        endcase
      end
      MEM_ADDR:  state_next = is_store ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (last) state_next = MEM_WB;
      MEM_WB:    state_next = FETCH;
      MEM_WRITE: if (last) state_next = FETCH;
      RTYPE:     state_next = RTYPE_WB;
      RTYPE_WB:  state_next = FETCH;
      ADDI_EX:   state_next = ADDI_WB;
      ADDI_WB:   state_next = FETCH;
      BRANCH:    state_next = FETCH;
      JUMP:      state_next = FETCH;
      TRAP:      state_next = TRAP;
      default:   state_next = FETCH;
    endcase
  end

  // Counter runs only while holding a memory state; any state change clears it.
  always_comb begin
    wc_next = '0;
    if (mem_state && (state_next == state)) wc_next = wc + WC_W'(1);
  end

  // Moore output decode (BranchNe additionally looks at Op in BRANCH).
  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    MDRWrite    = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = ALU_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    AWrite      = 1'b0;
    BWrite      = 1'b0;
    ALUOutWrite = 1'b0;
    Illegal     = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = last;
        PCWrite = last;
      end
      DECODE: begin
        AWrite      = 1'b1;
        BWrite      = 1'b1;
        ALUSrcB     = 2'b11;
        ALUOutWrite = 1'b1;
      end
      MEM_ADDR, ADDI_EX: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALUOutWrite = 1'b1;
      end
      MEM_READ: begin
        IorD     = 1'b1;
        MDRWrite = last;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      RTYPE: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_FUNCT;
        ALUOutWrite = 1'b1;
      end
      RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      ADDI_WB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNe    = (Op == OP_BNE);
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      TRAP:    Illegal = 1'b1;
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//   Directed bench for mips_multicycle_ctrl. Five instances share clock, reset
//   and Op and differ only in parameters:
//     0: MEM_WAIT=0 trap   1: MEM_WAIT=2   2: MEM_WAIT=1   3: MEM_WAIT=3
//     4: MEM_WAIT=0 with undefined opcodes treated as NOP
//   Each step compares one instance's State and its full output vector with
//   values written out from the state action table.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  localparam int N = 5;

  function automatic int wait_of(int i);
    case (i)
      1:       return 2;
      2:       return 1;
      3:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit trap_of(int i);
    return (i != 4);
  endfunction

  logic       Clk;
  logic       Reset;
  logic [5:0] Op;

  logic       pcwc [N], pcw [N], bne [N], iord [N], mw [N], m2r [N], irw [N], mdrw [N];
  logic [1:0] pcs [N];
  logic [2:0] aluop [N];
  logic       srca [N];
  logic [1:0] srcb [N];
  logic       rw [N], rdst [N], aw [N], bw [N], aow [N], ill [N];
  logic [3:0] st [N];

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mips_multicycle_ctrl #(
      .MEM_WAIT       (wait_of(g)),
      .ALUOP_W        (3),
      .TRAP_ON_ILLEGAL(trap_of(g))
    ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Op         (Op),
      .PCWriteCond(pcwc[g]),
      .PCWrite    (pcw[g]),
      .BranchNe   (bne[g]),
      .IorD       (iord[g]),
      .MemWrite   (mw[g]),
      .MemtoReg   (m2r[g]),
      .IRWrite    (irw[g]),
      .MDRWrite   (mdrw[g]),
      .PCSource   (pcs[g]),
      .ALUOp      (aluop[g]),
      .ALUSrcA    (srca[g]),
      .ALUSrcB    (srcb[g]),
      .RegWrite   (rw[g]),
      .RegDst     (rdst[g]),
      .AWrite     (aw[g]),
      .BWrite     (bw[g]),
      .ALUOutWrite(aow[g]),
      .Illegal    (ill[g]),
      .State      (st[g])
    );
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Field order of the packed control vector used for comparison.
  function automatic logic [21:0] pack_ctl(
    logic f_pcwc, logic f_pcw, logic f_bne, logic f_iord, logic f_mw,
    logic f_m2r, logic f_irw, logic f_mdrw, logic [1:0] f_pcs,
    logic [2:0] f_aluop, logic f_srca, logic [1:0] f_srcb, logic f_rw,
    logic f_rdst, logic f_aw, logic f_bw, logic f_aow, logic f_ill);
    return {f_pcwc, f_pcw, f_bne, f_iord, f_mw, f_m2r, f_irw, f_mdrw, f_pcs,
            f_aluop, f_srca, f_srcb, f_rw, f_rdst, f_aw, f_bw, f_aow, f_ill};
  endfunction

  function automatic logic [21:0] ctl_of(int d);
    return pack_ctl(pcwc[d], pcw[d], bne[d], iord[d], mw[d], m2r[d], irw[d],
                    mdrw[d], pcs[d], aluop[d], srca[d], srcb[d], rw[d],
                    rdst[d], aw[d], bw[d], aow[d], ill[d]);
  endfunction

  // Expected outputs per state, written from the action table.
  //                      pcwc pcw bne iord mw m2r irw mdrw pcs aluop srca srcb rw rdst aw bw aow ill
  function automatic logic [21:0] exp_ctl(int s, bit last, bit ne);
    case (s)
      1:  return pack_ctl(0, last, 0,  0,  0, 0, last, 0, 2'b00, 3'd0, 0, 2'b01, 0, 0, 0, 0, 0, 0);
      2:  return pack_ctl(0, 0,    0,  0,  0, 0, 0,    0, 2'b00, 3'd0, 0, 2'b11, 0, 0, 1, 1, 1, 0);
      3:  return pack_ctl(0, 0,    0,  0,  0, 0, 0,    0, 2'b00, 3'd0, 1, 2'b10, 0, 0, 0, 0, 1, 0);
      4:  return pack_ctl(0, 0,    0,  1,  0, 0, 0, last, 2'b00, 3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      5:  return pack_ctl(0, 0,    0,  0,  0, 1, 0,    0, 2'b00, 3'd0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
      6:  return pack_ctl(0, 0,    0,  1,  1, 0, 0,    0, 2'b00, 3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      7:  return pack_ctl(0, 0,    0,  0,  0, 0, 0,    0, 2'b00, 3'd2, 1, 2'b00, 0, 0, 0, 0, 1, 0);
      8:  return pack_ctl(0, 0,    0,  0,  0, 0, 0,    0, 2'b00, 3'd0, 0, 2'b00, 1, 1, 0, 0, 0, 0);
      9:  return pack_ctl(0, 0,    0,  0,  0, 0, 0,    0, 2'b00, 3'd0, 1, 2'b10, 0, 0, 0, 0, 1, 0);
      10: return pack_ctl(0, 0,    0,  0,  0, 0, 0,    0, 2'b00, 3'd0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
      11: return pack_ctl(1, 0,    ne, 0,  0, 0, 0,    0, 2'b01, 3'd1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
      12: return pack_ctl(0, 1,    0,  0,  0, 0, 0,    0, 2'b10, 3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      13: return pack_ctl(0, 0,    0,  0,  0, 0, 0,    0, 2'b00, 3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
      default: return '0;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare State and the full output vector of instance d.
  task automatic see(int d, int s, bit last, bit ne, string tag);
    check({tag, " state"}, 32'(st[d]), 32'(s));
    check({tag, " ctl"},   32'(ctl_of(d)), 32'(exp_ctl(s, last, ne)));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Two reset cycles with Op applied, then release away from the edge.
  task automatic start(logic [5:0] op);
    Reset = 1'b0;
    Op    = op;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0;
    Op    = 6'h00;

    // R-type, W=0: 0,0,0,1,2,7,8,1
    for (int i = 0; i < 3; i++) begin
      tick();
      see(0, 0, 0, 0, "rst");
    end
    Reset = 1'b1;
    tick(); see(0, 1, 1, 0, "r fetch");
    tick(); see(0, 2, 0, 0, "r decode");
    tick(); see(0, 7, 0, 0, "r exec");
    tick(); see(0, 8, 0, 0, "r wb");
    tick(); see(0, 1, 1, 0, "r next fetch");

    // LW, W=2: IRWrite/PCWrite on 3rd FETCH cycle, MDRWrite on 3rd MEM_READ, MEM_WB at cycle 9
    start(6'h23);
    for (int i = 0; i < 3; i++) begin
      tick(); see(1, 1, (i == 2), 0, "lw fetch");
    end
    tick(); see(1, 2, 0, 0, "lw decode");
    tick(); see(1, 3, 0, 0, "lw addr");
    for (int i = 0; i < 3; i++) begin
      tick(); see(1, 4, (i == 2), 0, "lw read");
    end
    tick(); see(1, 5, 0, 0, "lw wb");
    tick(); see(1, 1, 0, 0, "lw next fetch");

    // SW, W=1: 6 cycles, MemWrite for 2
    start(6'h2B);
    tick(); see(2, 1, 0, 0, "sw fetch0");
    tick(); see(2, 1, 1, 0, "sw fetch1");
    tick(); see(2, 2, 0, 0, "sw decode");
    tick(); see(2, 3, 0, 0, "sw addr");
    tick(); see(2, 6, 0, 0, "sw write0");
    tick(); see(2, 6, 0, 0, "sw write1");
    tick(); see(2, 1, 0, 0, "sw next fetch");

    // BEQ, BNE, J, ADDI and LW with Op disturbed after DECODE, W=0
    start(6'h04);
    tick(); see(0, 1, 1, 0, "beq fetch");
    tick(); see(0, 2, 0, 0, "beq decode");
    tick(); see(0, 11, 0, 0, "beq branch");
    Op = 6'h05;
    tick(); see(0, 1, 1, 0, "bne fetch");
    tick(); see(0, 2, 0, 0, "bne decode");
    tick(); see(0, 11, 0, 1, "bne branch");
    Op = 6'h02;
    tick(); see(0, 1, 1, 0, "j fetch");
    tick(); see(0, 2, 0, 0, "j decode");
    tick(); see(0, 12, 0, 0, "j jump");
    Op = 6'h08;
    tick(); see(0, 1, 1, 0, "addi fetch");
    tick(); see(0, 2, 0, 0, "addi decode");
    tick(); see(0, 9, 0, 0, "addi exec");
    Op = 6'h00;
    tick(); see(0, 10, 0, 0, "addi wb op changed");
    Op = 6'h23;
    tick(); see(0, 1, 1, 0, "lw2 fetch");
    tick(); see(0, 2, 0, 0, "lw2 decode");
    tick(); see(0, 3, 0, 0, "lw2 addr");
    Op = 6'h2B;
    tick(); see(0, 4, 1, 0, "lw2 read op changed");
    tick(); see(0, 5, 0, 0, "lw2 wb");
    tick(); see(0, 1, 1, 0, "lw2 next fetch");

    // Undefined Op 3F: trap (instance 0) versus NOP (instance 4)
    start(6'h3F);
    tick(); see(0, 1, 1, 0, "ill fetch");  see(4, 1, 1, 0, "nop fetch");
    tick(); see(0, 2, 0, 0, "ill decode"); see(4, 2, 0, 0, "nop decode");
    tick(); see(0, 13, 0, 0, "ill trap");  see(4, 1, 1, 0, "nop back to fetch");
    Op = 6'h00;
    for (int i = 1; i < 20; i++) begin
      tick(); see(0, 13, 0, 0, "ill trap held");
    end
    Reset = 1'b0;
    #1;
    see(0, 0, 0, 0, "trap async reset");

    // Reset on 2nd MEM_READ cycle with W=3, then full 4-cycle FETCH
    Op = 6'h23;
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); see(3, 1, (i == 3), 0, "w3 fetch");
    end
    tick(); see(3, 2, 0, 0, "w3 decode");
    tick(); see(3, 3, 0, 0, "w3 addr");
    tick(); see(3, 4, 0, 0, "w3 read0");
    tick(); see(3, 4, 0, 0, "w3 read1");
    Reset = 1'b0;
    #1;
    see(3, 0, 0, 0, "w3 async reset");
    tick(); see(3, 0, 0, 0, "w3 reset held");
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); see(3, 1, (i == 3), 0, "w3 refetch");
    end
    tick(); see(3, 2, 0, 0, "w3 redecode");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
